// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_if
//  Description : Handshake bundle for the packed-BCD to binary converter.
//                Carries the input word channel (valid/ready/bcd) and the
//                result channel (valid/ready/bin/err).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  // Input word channel
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;

  // Result channel
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;

  // Producer/consumer side of the converter
  modport master (
    output in_valid,
    output in_bcd,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  out_err,
    output out_ready
  );

  // Converter side
  modport slave (
    input  in_valid,
    input  in_bcd,
    output in_ready,
    output out_valid,
    output out_bin,
    output out_err,
    input  out_ready
  );

endinterface : bcd_to_bin_if
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Sequential packed-BCD to binary converter. Accepts a
//                DIGITS-digit packed BCD word, folds it in most-significant
//                digit first (acc = acc*10 + digit, one digit per cycle) and
//                returns the binary value plus an illegal-nibble flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
  parameter int DIGITS = 4,   // 1..4
  parameter int BIN_W  = 14   // 2**BIN_W > 10**DIGITS - 1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  bcd_to_bin_if.slave bus
);

  // Digit index register width and the index of the most-significant digit
  localparam int                c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
  logic [BIN_W-1:0]      acc_q,     acc_d;
  logic [c_idx_w-1:0]    idx_q,     idx_d;
  logic                  err_q,     err_d;
  logic [BIN_W-1:0]      out_bin_q, out_bin_d;
  logic                  out_err_q, out_err_d;

  logic [DIGITS-1:0]     nib_bad;
  logic                  in_err;
  logic [3:0]            cur_digit;
  logic [BIN_W-1:0]      acc_x10;
  logic [BIN_W-1:0]      acc_next;

  // Flag every incoming nibble above 9; the word is illegal if any is.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_nib_chk
      assign nib_bad[k] = (bus.in_bcd[4*k +: 4] > 4'd9);
    end
  endgenerate

  assign in_err = |nib_bad;

  // Select the digit addressed by the current index from the captured word.
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == c_idx_w'(k)) begin
        cur_digit = bcd_q[4*k +: 4];
      end
    end
  end

  // Multiply-by-ten as two shifts and an add, then fold in the digit.
  assign acc_x10  = (acc_q << 3) + (acc_q << 1);
  assign acc_next = acc_x10 + BIN_W'(cur_digit);

  // Next-state and datapath update for the IDLE -> CONV -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;

    case (state_q)
      IDLE: begin
        // in_ready is implied by being in IDLE
        if (bus.in_valid) begin
          bcd_d   = bus.in_bcd;
          acc_d   = '0;
          idx_d   = c_idx_last;
          err_d   = in_err;
          state_d = CONV;
        end
      end

      CONV: begin
        // Illegal digits are still accumulated; the result is masked below.
        acc_d = acc_next;
        if (idx_q == '0) begin
          idx_d     = c_idx_last;
          out_bin_d = err_q ? '0 : acc_next;
          out_err_d = err_q;
          state_d   = DONE;
        end else begin
          idx_d = idx_q - c_idx_w'(1);
        end
      end

      DONE: begin
        // Results stay on out_bin/out_err after the transfer until the next DONE.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      acc_q     <= '0;
      idx_q     <= c_idx_last;
      err_q     <= 1'b0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  // Handshake outputs decode the state register only, so neither in_valid
  // nor out_ready has a combinational path to any output.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

endmodule : bcd_to_bin
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin
//  Description : Self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=14).
//                Expected results are queued when a word is driven and
//                compared when the converter presents its result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic clk;
  logic reset;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected {err, bin} per accepted word, in acceptance order
  logic [BIN_W:0] sb[$];
  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every local bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the presented result against the oldest queued expectation
  task automatic check_pop(input string tag);
    logic [BIN_W:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: result with empty scoreboard, observed %0d expected none", tag, bus.out_bin);
    end else begin
      e = sb.pop_front();
      check({tag, " err"}, 32'(bus.out_err), 32'(e[BIN_W]));
      check({tag, " bin"}, 32'(bus.out_bin), 32'(e[BIN_W-1:0]));
    end
  endtask

  // One full conversion with out_ready high: acceptance, latency, result, release
  task automatic convert(input string tag, input logic [15:0] w, input int exp_bin, input bit exp_err);
    int n;
    bus.in_bcd    = w;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, " accept in time"}, 32'(n < 50), 32'd1);
    sb.push_back({exp_err, BIN_W'(exp_bin)});
    tick();                       // E0: word accepted
    bus.in_valid = 1'b0;
    bus.in_bcd   = 16'hFFFF;      // must not disturb the captured word
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check_pop(tag);
    tick();                       // E5: output transfer
    check({tag, " in_ready after xfer"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid after xfer"}, 32'(bus.out_valid), 32'd0);
    check({tag, " bin held after xfer"}, 32'(bus.out_bin), 32'(exp_bin));
  endtask

  initial begin
    int n;
    int cnt;
    int sent;
    int got;
    int cyc;
    logic [15:0] words[100];
    int          vals[100];

    n_cmp = 0;
    n_bad = 0;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_bin",   32'(bus.out_bin),   32'd0);
    check("reset out_err",   32'(bus.out_err),   32'd0);

    // Basic and boundary conversions
    convert("w1234", 16'h1234, 1234, 1'b0);
    convert("w0000", 16'h0000, 0,    1'b0);
    convert("w0009", 16'h0009, 9,    1'b0);
    convert("w0010", 16'h0010, 10,   1'b0);
    convert("w9999", 16'h9999, 9999, 1'b0);

    // Illegal nibbles force bin=0 and err=1
    convert("w12A4", 16'h12A4, 0,  1'b1);
    convert("wF000", 16'hF000, 0,  1'b1);
    convert("w0042", 16'h0042, 42, 1'b0);

    // Backpressure: stall in DONE, offered word must wait
    bus.in_bcd    = 16'h0777;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    sb.push_back({1'b0, BIN_W'(777)});
    tick();                       // E0
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("stall latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bcd   = 16'h5555;
      tick();
      check($sformatf("stall%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d out_bin", i),   32'(bus.out_bin),   32'd777);
      check($sformatf("stall%0d out_err", i),   32'(bus.out_err),   32'd0);
      check($sformatf("stall%0d in_ready", i),  32'(bus.in_ready),  32'd0);
    end
    check_pop("w0777");
    bus.out_ready = 1'b1;
    tick();                       // single transfer
    check("post-stall out_valid", 32'(bus.out_valid), 32'd0);
    check("post-stall in_ready",  32'(bus.in_ready),  32'd1);
    convert("w5555", 16'h5555, 5555, 1'b0);

    // Reset at E2 aborts the conversion with no output
    bus.in_bcd    = 16'h8765;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();                       // E0
    bus.in_valid = 1'b0;
    tick();                       // E1
    reset = 1'b1;
    tick();                       // E2 sees reset
    reset = 1'b0;
    check("abort in_ready",  32'(bus.in_ready),  32'd1);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort out_bin",   32'(bus.out_bin),   32'd0);
    check("abort out_err",   32'(bus.out_err),   32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) cnt++;
    end
    check("abort no output", 32'(cnt), 32'd0);
    convert("w0001", 16'h0001, 1, 1'b0);

    // Back-to-back random legal words with random backpressure
    for (int i = 0; i < 100; i++) begin
      logic [3:0] d0, d1, d2, d3;
      d0 = 4'($urandom_range(0, 9));
      d1 = 4'($urandom_range(0, 9));
      d2 = 4'($urandom_range(0, 9));
      d3 = 4'($urandom_range(0, 9));
      words[i] = {d3, d2, d1, d0};
      vals[i]  = int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = words[0];
    bus.out_ready = ($urandom_range(0, 3) != 0);
    while (got < 100 && cyc < 5000) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check_pop($sformatf("b2b%0d", got));
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        sb.push_back({1'b0, BIN_W'(vals[sent])});
        sent++;
      end
      tick();
      cyc++;
      if (sent < 100) begin
        bus.in_valid = 1'b1;
        bus.in_bcd   = words[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    check("b2b results received", 32'(got), 32'd100);
    check("b2b words sent",       32'(sent), 32'd100);
    check("b2b scoreboard empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bcd_to_bin
`default_nettype wire
